// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the data-memory round-robin arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } arb_state_t;

    localparam int MASK_W  = 3;
    localparam int STATS_W = 16;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - combinational round-robin selector: first set request at or after rr_ptr, wrapping
module rr_picker #(
    parameter int NUM_CORES = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [IDX_W-1:0]     winner,
    output logic                 valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = IDX_W'((int'(rr_ptr) + i) % NUM_CORES);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one data-memory port among NUM_CORES cache controllers
// Optional per-core grant and contention counters are built when MEM_ARBITER_STATS_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    input  logic [NUM_CORES*MASK_W-1:0] core_mask,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic [MASK_W-1:0]           mem_mask,
    output logic                        mem_wr_en,
    output logic                        mem_rd_en,
    input  logic [DATA_W-1:0]           mem_rdata
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [NUM_CORES*STATS_W-1:0] grant_cnt,
    output logic [STATS_W-1:0]           contention_cnt
`endif
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win;
    logic             we_q;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] pick;
    logic             pick_valid;

    rr_picker #(
        .NUM_CORES(NUM_CORES),
        .IDX_W    (IDX_W)
    ) u_picker (
        .req   (core_req),
        .rr_ptr(rr_ptr),
        .winner(pick),
        .valid (pick_valid)
    );

    // The memory-side registers double as the latched payload of the granted core.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            win        <= '0;
            we_q       <= 1'b0;
            cnt        <= '0;
            core_ack   <= '0;
            core_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_mask   <= '0;
            mem_wr_en  <= 1'b0;
            mem_rd_en  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    core_ack <= '0;
                    if (pick_valid) begin
                        win       <= pick;
                        we_q      <= core_we[pick];
                        mem_addr  <= core_addr[pick*ADDR_W +: ADDR_W];
                        mem_wdata <= core_wdata[pick*DATA_W +: DATA_W];
                        mem_mask  <= core_mask[pick*MASK_W +: MASK_W];
                        mem_wr_en <= core_we[pick];
                        mem_rd_en <= !core_we[pick];
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_wr_en <= 1'b0;
                    mem_rd_en <= 1'b0;
                    if (we_q) begin
                        core_ack <= NUM_CORES'(1) << win;
                        state    <= DONE;
                    end else if (MEM_LAT == 1) begin
                        core_rdata <= mem_rdata;
                        core_ack   <= NUM_CORES'(1) << win;
                        state      <= DONE;
                    end else begin
                        cnt   <= CNT_W'(MEM_LAT - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        core_rdata <= mem_rdata;
                        core_ack   <= NUM_CORES'(1) << win;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    core_ack <= '0;
                    rr_ptr   <= (int'(win) == NUM_CORES - 1) ? '0 : win + 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt      <= '0;
            contention_cnt <= '0;
        end else begin
            if (state == IDLE && pick_valid && $countones(core_req) >= 2)
                contention_cnt <= sat_inc(contention_cnt);
            if (state == DONE)
                grant_cnt[win*STATS_W +: STATS_W] <= sat_inc(grant_cnt[win*STATS_W +: STATS_W]);
        end
    end
`else
    // Base build carries no statistics state.
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (stats checks when MEM_ARBITER_STATS_EN is defined)
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    core_req;
    logic [N-1:0]    core_we;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdata;
    logic [N*3-1:0]  core_mask;
    logic [N-1:0]    core_ack;
    logic [DW-1:0]   core_rdata;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [2:0]      mem_mask;
    logic            mem_wr_en;
    logic            mem_rd_en;
    logic [DW-1:0]   mem_rdata;
`ifdef MEM_ARBITER_STATS_EN
    logic [N*16-1:0] grant_cnt;
    logic [15:0]     contention_cnt;
`endif

    mem_arbiter #(
        .NUM_CORES(N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MEM_LAT  (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .core_req  (core_req),
        .core_we   (core_we),
        .core_addr (core_addr),
        .core_wdata(core_wdata),
        .core_mask (core_mask),
        .core_ack  (core_ack),
        .core_rdata(core_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_mask  (mem_mask),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .grant_cnt     (grant_cnt),
        .contention_cnt(contention_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] ack;
        bit           rd;
        logic [31:0]  data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   ack_cnt[N];
    int   exp_ptr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h80) ? 32'h1234_5678 : {~a[15:0], a[15:0]};
    endfunction

    // Memory with one cycle of read latency; a stale marker shows up if the DUT captures at the wrong cycle.
    logic [31:0] rd_pipe;
    always @(posedge clk) rd_pipe <= mem_rd_en ? mem_val(mem_addr) : 32'hBAD0_BAD0;
    assign mem_rdata = rd_pipe;

    always @(negedge clk) begin
        if (reset) begin
            for (int c = 0; c < N; c++) ack_cnt[c] = 0;
        end else if (core_ack != '0) begin
            check("ack_onehot", 64'($onehot(core_ack)), 64'(1));
            if (sb.size() == 0) begin
                check("unexp_ack", 64'(core_ack), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_vec", 64'(core_ack), 64'(e.ack));
                if (e.rd) check("rdata", 64'(core_rdata), 64'(e.data));
            end
            for (int c = 0; c < N; c++) if (core_ack[c]) ack_cnt[c]++;
        end
    end

    task automatic do_reset();
        reset      = 1'b1;
        core_req   = '0;
        core_we    = '0;
        core_addr  = '0;
        core_wdata = '0;
        core_mask  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        exp_ptr = 0;
    endtask

    task automatic single(input int c, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] m);
        exp_t e;
        int   lat;
        e.ack  = N'(1) << c;
        e.rd   = !we;
        e.data = mem_val(a);
        sb.push_back(e);
        @(negedge clk);
        core_req[c]            = 1'b1;
        core_we[c]             = we;
        core_addr[c*AW +: AW]  = a;
        core_wdata[c*DW +: DW] = wd;
        core_mask[c*3 +: 3]    = m;
        @(posedge clk);
        #1;
        check("strobe_wr", 64'(mem_wr_en), 64'(we));
        check("strobe_rd", 64'(mem_rd_en), 64'(!we));
        check("mem_addr", 64'(mem_addr), 64'(a));
        if (we) begin
            check("mem_wdata", 64'(mem_wdata), 64'(wd));
            check("mem_mask", 64'(mem_mask), 64'(m));
        end
        lat = 1;
        while (core_ack == '0 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            check("strobe_off", 64'(mem_wr_en | mem_rd_en), 64'(0));
        end
        check("latency", 64'(lat), 64'(we ? 2 : LAT + 1));
        exp_ptr = (c + 1) % N;
        @(negedge clk);
        core_req[c] = 1'b0;
    endtask

    // Both cores issue back-to-back reads; grant order is predicted from the round-robin pointer.
    task automatic run_both(input int n0, input int n1, input logic [31:0] b0, input logic [31:0] b1);
        int          n[N];
        int          rem[N];
        int          sent[N];
        logic [31:0] base[N];
        int          ptr;
        int          p;
        int          cyc;
        exp_t        e;
        n    = '{n0, n1};
        rem  = '{n0, n1};
        sent = '{0, 0};
        base = '{b0, b1};
        ptr  = exp_ptr;
        while (rem[0] + rem[1] > 0) begin
            p = -1;
            for (int k = 0; k < N; k++)
                if (p < 0 && rem[(ptr + k) % N] > 0) p = (ptr + k) % N;
            e.ack  = N'(1) << p;
            e.rd   = 1'b1;
            e.data = mem_val(base[p] + 32'(4 * sent[p]));
            sb.push_back(e);
            sent[p]++;
            rem[p]--;
            ptr = (p + 1) % N;
        end
        exp_ptr = ptr;
        sent = '{0, 0};
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
            core_req[c]           = (n[c] > 0);
            core_we[c]            = 1'b0;
            core_addr[c*AW +: AW] = base[c];
        end
        cyc = 0;
        while ((sent[0] < n[0] || sent[1] < n[1]) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            for (int c = 0; c < N; c++) begin
                if (core_ack[c]) begin
                    sent[c]++;
                    if (sent[c] >= n[c]) core_req[c] = 1'b0;
                    else core_addr[c*AW +: AW] = base[c] + 32'(4 * sent[c]);
                end
            end
        end
        check("both_timeout", 64'(cyc < 200), 64'(1));
    endtask

    initial begin
        do_reset();
        check("rst_ack", 64'(core_ack), 64'(0));
        check("rst_strobes", 64'({mem_wr_en, mem_rd_en}), 64'(0));
        check("rst_rdata", 64'(core_rdata), 64'(0));
        check("rst_mem", 64'({mem_addr, mem_wdata[15:0], 13'd0, mem_mask}), 64'(0));

        single(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 3'b010);
        single(1, 1'b0, 32'h80, 32'h0, 3'b000);
        check("rdata_hold", 64'(core_rdata), 64'(32'h1234_5678));
        single(0, 1'b1, 32'h44, 32'hCAFE_F00D, 3'b111);
        check("rdata_after_wr", 64'(core_rdata), 64'(32'h1234_5678));

        run_both(2, 2, 32'h200, 32'h300);
        single(1, 1'b0, 32'h88, 32'h0, 3'b000);
        single(0, 1'b1, 32'h90, 32'h5555_AAAA, 3'b001);

        // Abort a read while the arbiter waits on memory latency.
        @(negedge clk);
        core_req[0]           = 1'b1;
        core_we[0]            = 1'b0;
        core_addr[0*AW +: AW] = 32'h100;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        core_req = '0;
        @(posedge clk);
        #1;
        check("abort_ack", 64'(core_ack), 64'(0));
        check("abort_strobes", 64'({mem_wr_en, mem_rd_en}), 64'(0));
        check("abort_rdata", 64'(core_rdata), 64'(0));
        check("abort_addr", 64'(mem_addr), 64'(0));
        @(negedge clk);
        reset   = 1'b0;
        exp_ptr = 0;
        repeat (4) @(negedge clk);

        run_both(3, 3, 32'h400, 32'h500);
        repeat (3) @(negedge clk);
        check("acks_core0", 64'(ack_cnt[0]), 64'(3));
        check("acks_core1", 64'(ack_cnt[1]), 64'(3));
`ifdef MEM_ARBITER_STATS_EN
        check("contention_cnt", 64'(contention_cnt), 64'(5));
        check("grant_cnt0", 64'(grant_cnt[15:0]), 64'(ack_cnt[0]));
        check("grant_cnt1", 64'(grant_cnt[31:16]), 64'(ack_cnt[1]));
`endif
        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

endmodule
